memwrite_checker: RTL and testbench

Synthesizable self-checking monitor for the MIPS processor's data-memory write port. It holds a programmable table of up to DEPTH expected (address, data) writes, watches `memwrite`/`dataadr`/`writedata` once armed, and reports pass/fail with a cycle timeout. It sits beside `top` in simulation and on FPGA bring-up boards, and replaces per-test hand-coded compare logic with a loadable, multi-write, ordered or unordered check.

---
 rtl/memwrite_checker_if.sv | 64 ++++++
 rtl/memwrite_checker.sv | 199 +++++++++++++++++++
 tb/tb_memwrite_checker.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memwrite_checker_if.sv
// memwrite_checker_if
//   Bundles everything memwrite_checker exchanges with its surroundings except
//   clock and reset: the expected-table load port, the run control, the
//   observed store bus from the processor and the registered status outputs.
//
//   Signal groups
//     control : start, ordered, exp_count
//     table   : exp_we, exp_idx, exp_addr, exp_data
//     store   : memwrite, dataadr, writedata
//     status  : busy, done, pass, fail, timeout, hits, mismatches,
//               bad_addr, bad_data, cycles, dbg_state
//
//   Modports
//     master : drives control/table/store, observes status (bench or SoC glue)
//     slave  : the checker itself
interface memwrite_checker_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Control and table load
    logic          start;
    logic          ordered;
    logic [CW-1:0] exp_count;
    logic          exp_we;
    logic [IW-1:0] exp_idx;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    // Observed processor store port
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;

    // Status
    logic          busy;
    logic          done;
    logic          pass;
    logic          fail;
    logic          timeout;
    logic [CW-1:0] hits;
    logic [7:0]    mismatches;
    logic [AW-1:0] bad_addr;
    logic [DW-1:0] bad_data;
    logic [31:0]   cycles;
    logic [1:0]    dbg_state;

    modport master (
        output start, ordered, exp_count, exp_we, exp_idx, exp_addr, exp_data,
        output memwrite, dataadr, writedata,
        input  busy, done, pass, fail, timeout, hits, mismatches,
        input  bad_addr, bad_data, cycles, dbg_state
    );

    modport slave (
        input  start, ordered, exp_count, exp_we, exp_idx, exp_addr, exp_data,
        input  memwrite, dataadr, writedata,
        output busy, done, pass, fail, timeout, hits, mismatches,
        output bad_addr, bad_data, cycles, dbg_state
    );
endinterface

// File: rtl/memwrite_checker.sv
// memwrite_checker
//   Self-checking monitor for the MIPS data-memory write port. A table of up
//   to DEPTH expected (address, data) stores is loaded while idle; a start
//   pulse arms a run, after which every memwrite is compared against the
//   table either in strict order or in any order. The run ends in PASS when
//   all latched entries have been hit, or in FAIL on an ordered mismatch or
//   when TIMEOUT cycles elapse.
//
//   Ports
//     clk   : rising-edge clock
//     reset : asynchronous, active-low; returns to IDLE and clears the table
//     bus   : memwrite_checker_if.slave (control, table, store, status)
//
//   Strobe semantics: there is no valid/ready handshake. start, exp_we and
//   memwrite are single-cycle qualifiers sampled on the rising edge; the
//   checker never back-pressures, so every asserted strobe is consumed on the
//   edge where it is seen (exp_we is dropped while a run is in progress).
module memwrite_checker #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 100
) (
    input logic               clk,
    input logic               reset,
    memwrite_checker_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] tab_addr_q [DEPTH];
    logic [DW-1:0] tab_data_q [DEPTH];
    logic [DEPTH-1:0] hit_q, hit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ord_q, ord_d;
    logic [CW-1:0] hits_q, hits_d;
    logic [7:0]    mism_q, mism_d;
    logic [AW-1:0] bad_addr_q, bad_addr_d;
    logic [DW-1:0] bad_data_q, bad_data_d;
    logic [31:0]   cycles_q, cycles_d;
    logic          tmo_q, tmo_d;

    logic          tab_we;
    logic [IW-1:0] ord_idx;
    logic          ord_match;
    logic          uo_found;
    logic [IW-1:0] uo_sel;
    logic [CW-1:0] hits_nxt;
    logic          mismatch;
    logic [31:0]   cyc_inc;

    // The table is frozen during a run so the expectations cannot shift
    // under an in-flight comparison.
    assign tab_we = bus.exp_we && (state_q != S_RUN) && (int'(bus.exp_idx) < DEPTH);

    // In ordered mode the next expected entry is always entry[hits].
    assign ord_idx   = hits_q[IW-1:0];
    assign ord_match = (bus.dataadr == tab_addr_q[ord_idx]) &&
                       (bus.writedata == tab_data_q[ord_idx]);

    assign cyc_inc = (cycles_q != 32'hFFFF_FFFF) ? cycles_q + 32'd1 : cycles_q;

    // Unordered search: lowest-index valid entry not yet hit that matches.
    always_comb begin
        uo_found = 1'b0;
        uo_sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!uo_found && (CW'(i) < cnt_q) && !hit_q[i] &&
                (bus.dataadr == tab_addr_q[i]) && (bus.writedata == tab_data_q[i])) begin
                uo_found = 1'b1;
                uo_sel   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hit_d      = hit_q;
        cnt_d      = cnt_q;
        ord_d      = ord_q;
        hits_d     = hits_q;
        mism_d     = mism_q;
        bad_addr_d = bad_addr_q;
        bad_data_d = bad_data_q;
        cycles_d   = cycles_q;
        tmo_d      = tmo_q;
        hits_nxt   = hits_q;
        mismatch   = 1'b0;

        if (bus.start) begin
            // start wins over everything else on the same edge.
            state_d    = S_RUN;
            hit_d      = '0;
            hits_d     = '0;
            mism_d     = '0;
            bad_addr_d = '0;
            bad_data_d = '0;
            cycles_d   = '0;
            tmo_d      = 1'b0;
            ord_d      = bus.ordered;
            cnt_d      = (int'(bus.exp_count) > DEPTH) ? CW'(DEPTH) : bus.exp_count;
        end else if (state_q == S_RUN) begin
            if (cnt_q == '0) begin
                state_d  = S_PASS;
                cycles_d = cyc_inc;
            end else begin
                if (bus.memwrite) begin
                    if (ord_q) begin
                        if (ord_match) hits_nxt = hits_q + CW'(1);
                        else           mismatch = 1'b1;
                    end else if (uo_found) begin
                        hit_d[uo_sel] = 1'b1;
                        hits_nxt      = hits_q + CW'(1);
                    end else begin
                        mismatch = 1'b1;
                    end
                end

                if (mismatch) begin
                    if (mism_q != 8'hFF) mism_d = mism_q + 8'd1;
                    // Only the first offending store is kept for debug.
                    if (mism_q == 8'd0) begin
                        bad_addr_d = bus.dataadr;
                        bad_data_d = bus.writedata;
                    end
                end
                hits_d = hits_nxt;

                // Completion beats an ordered mismatch, which beats timeout.
                if (hits_nxt == cnt_q) begin
                    state_d  = S_PASS;
                    cycles_d = cyc_inc;
                end else if (mismatch && ord_q) begin
                    state_d  = S_FAIL;
                    cycles_d = cyc_inc;
                end else if (cycles_q == 32'(TIMEOUT - 1)) begin
                    // The timeout edge leaves cycles at TIMEOUT-1.
                    state_d = S_FAIL;
                    tmo_d   = 1'b1;
                end else begin
                    cycles_d = cyc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            hit_q      <= '0;
            cnt_q      <= '0;
            ord_q      <= 1'b0;
            hits_q     <= '0;
            mism_q     <= '0;
            bad_addr_q <= '0;
            bad_data_q <= '0;
            cycles_q   <= '0;
            tmo_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tab_addr_q[i] <= '0;
                tab_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hit_q      <= hit_d;
            cnt_q      <= cnt_d;
            ord_q      <= ord_d;
            hits_q     <= hits_d;
            mism_q     <= mism_d;
            bad_addr_q <= bad_addr_d;
            bad_data_q <= bad_data_d;
            cycles_q   <= cycles_d;
            tmo_q      <= tmo_d;
            if (tab_we) begin
                tab_addr_q[bus.exp_idx] <= bus.exp_addr;
                tab_data_q[bus.exp_idx] <= bus.exp_data;
            end
        end
    end

    // Status is a pure decode of registers; nothing flows through from inputs.
    assign bus.busy       = (state_q == S_RUN);
    assign bus.pass       = (state_q == S_PASS);
    assign bus.fail       = (state_q == S_FAIL);
    assign bus.done       = (state_q == S_PASS) || (state_q == S_FAIL);
    assign bus.timeout    = tmo_q;
    assign bus.hits       = hits_q;
    assign bus.mismatches = mism_q;
    assign bus.bad_addr   = bad_addr_q;
    assign bus.bad_data   = bad_data_q;
    assign bus.cycles     = cycles_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_memwrite_checker.sv
module tb_memwrite_checker;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int TIMEOUT = 100;

    logic clk;
    logic reset;
    int errors;
    int checks;

    memwrite_checker_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    memwrite_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Driver tasks: inputs change 1 time unit after the rising edge, so
    // outputs observed at that point reflect the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input logic [1:0] idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.exp_we = 1'b1; bus.exp_idx = idx; bus.exp_addr = a; bus.exp_data = d;
        tick();
        bus.exp_we = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] cnt, input logic ord);
        bus.start = 1'b1; bus.exp_count = cnt; bus.ordered = ord;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
        tick();
        bus.memwrite = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b0;
        bus.start = 0; bus.ordered = 0; bus.exp_count = 0; bus.exp_we = 0;
        bus.exp_idx = 0; bus.exp_addr = 0; bus.exp_data = 0;
        bus.memwrite = 0; bus.dataadr = 0; bus.writedata = 0;
        #3;
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout, bus.dbg_state} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0", {bus.busy, bus.done, bus.pass, bus.fail, bus.timeout, bus.dbg_state});
        end
        checks++;
        if ({bus.hits, bus.mismatches, bus.bad_addr, bus.bad_data, bus.cycles} !== '0) begin
            errors++; $display("FAIL reset_counters: hits=%0d mism=%0d bad_addr=%0h bad_data=%0h cycles=%0d expected all 0",
                               bus.hits, bus.mismatches, bus.bad_addr, bus.bad_data, bus.cycles);
        end
        #4 reset = 1'b1;
        tick();
    endtask

    task automatic test_ordered_single();
        load_entry(2'd0, 32'h14, 32'd21);
        do_start(3'd1, 1'b1);
        checks++;
        if ({bus.busy, bus.done, bus.cycles} !== {1'b1, 1'b0, 32'd0}) begin
            errors++; $display("FAIL start_busy: busy=%b done=%b cycles=%0d expected 1 0 0", bus.busy, bus.done, bus.cycles);
        end
        repeat (19) tick();
        store(32'h14, 32'd21);
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout} !== 5'b01100) begin
            errors++; $display("FAIL single_pass_flags: got %b expected 01100", {bus.busy, bus.done, bus.pass, bus.fail, bus.timeout});
        end
        checks++;
        if ({bus.hits, bus.cycles, bus.mismatches} !== {3'd1, 32'd20, 8'd0}) begin
            errors++; $display("FAIL single_pass_counts: hits=%0d cycles=%0d mism=%0d expected 1 20 0", bus.hits, bus.cycles, bus.mismatches);
        end
    endtask

    task automatic test_ordered_reverse();
        load_entry(2'd0, 32'h0, 32'd4);
        load_entry(2'd1, 32'hc, 32'h0c);
        do_start(3'd2, 1'b1);
        store(32'hc, 32'h0c);
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout} !== 5'b01010) begin
            errors++; $display("FAIL ord_rev_flags: got %b expected 01010", {bus.busy, bus.done, bus.pass, bus.fail, bus.timeout});
        end
        checks++;
        if ({bus.bad_addr, bus.bad_data, bus.mismatches, bus.hits} !== {32'hc, 32'h0c, 8'd1, 3'd0}) begin
            errors++; $display("FAIL ord_rev_bad: addr=%0h data=%0h mism=%0d hits=%0d expected c c 1 0",
                               bus.bad_addr, bus.bad_data, bus.mismatches, bus.hits);
        end
        // Stores after the run has ended must not touch the status.
        store(32'h0, 32'd4);
        checks++;
        if ({bus.fail, bus.mismatches, bus.hits} !== {1'b1, 8'd1, 3'd0}) begin
            errors++; $display("FAIL ord_rev_hold: fail=%b mism=%0d hits=%0d expected 1 1 0", bus.fail, bus.mismatches, bus.hits);
        end
    endtask

    task automatic test_unordered();
        do_start(3'd2, 1'b0);
        store(32'hc, 32'h0c);
        checks++;
        if ({bus.busy, bus.hits, bus.mismatches} !== {1'b1, 3'd1, 8'd0}) begin
            errors++; $display("FAIL unord_first: busy=%b hits=%0d mism=%0d expected 1 1 0", bus.busy, bus.hits, bus.mismatches);
        end
        store(32'h54, 32'd7);
        checks++;
        if ({bus.busy, bus.hits, bus.mismatches, bus.bad_addr, bus.bad_data} !== {1'b1, 3'd1, 8'd1, 32'h54, 32'd7}) begin
            errors++; $display("FAIL unord_extra: busy=%b hits=%0d mism=%0d addr=%0h data=%0h expected 1 1 1 54 7",
                               bus.busy, bus.hits, bus.mismatches, bus.bad_addr, bus.bad_data);
        end
        store(32'h0, 32'd4);
        checks++;
        if ({bus.pass, bus.fail, bus.hits, bus.mismatches, bus.bad_addr} !== {1'b1, 1'b0, 3'd2, 8'd1, 32'h54}) begin
            errors++; $display("FAIL unord_pass: pass=%b fail=%b hits=%0d mism=%0d addr=%0h expected 1 0 2 1 54",
                               bus.pass, bus.fail, bus.hits, bus.mismatches, bus.bad_addr);
        end
    endtask

    task automatic test_duplicate();
        // A second store to an already-hit entry is a mismatch in unordered mode.
        do_start(3'd2, 1'b0);
        store(32'h0, 32'd4);
        store(32'h0, 32'd4);
        checks++;
        if ({bus.busy, bus.hits, bus.mismatches, bus.bad_addr, bus.bad_data} !== {1'b1, 3'd1, 8'd1, 32'h0, 32'd4}) begin
            errors++; $display("FAIL dup_store: busy=%b hits=%0d mism=%0d addr=%0h data=%0h expected 1 1 1 0 4",
                               bus.busy, bus.hits, bus.mismatches, bus.bad_addr, bus.bad_data);
        end
    endtask

    task automatic test_timeout();
        int k;
        do_start(3'd2, 1'b1);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.done) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k !== 100) begin
            errors++; $display("FAIL timeout_edge: done after %0d cycles expected 100", k);
        end
        checks++;
        if ({bus.fail, bus.pass, bus.timeout, bus.cycles} !== {1'b1, 1'b0, 1'b1, 32'd99}) begin
            errors++; $display("FAIL timeout_status: fail=%b pass=%b timeout=%b cycles=%0d expected 1 0 1 99",
                               bus.fail, bus.pass, bus.timeout, bus.cycles);
        end
    endtask

    task automatic test_count_zero();
        do_start(3'd0, 1'b1);
        checks++;
        if ({bus.busy, bus.timeout} !== 2'b10) begin
            errors++; $display("FAIL zero_busy: busy=%b timeout=%b expected 1 0", bus.busy, bus.timeout);
        end
        tick();
        checks++;
        if ({bus.pass, bus.busy, bus.hits} !== {1'b1, 1'b0, 3'd0}) begin
            errors++; $display("FAIL zero_pass: pass=%b busy=%b hits=%0d expected 1 0 0", bus.pass, bus.busy, bus.hits);
        end
    endtask

    task automatic test_count_clamp();
        for (int i = 0; i < 4; i++) load_entry(2'(i), 32'h100 + 32'(i * 4), 32'(i + 1));
        do_start(3'd7, 1'b0);
        store(32'h10c, 32'd4);
        store(32'h104, 32'd2);
        store(32'h100, 32'd1);
        checks++;
        if ({bus.busy, bus.hits} !== {1'b1, 3'd3}) begin
            errors++; $display("FAIL clamp_partial: busy=%b hits=%0d expected 1 3", bus.busy, bus.hits);
        end
        store(32'h108, 32'd3);
        checks++;
        if ({bus.pass, bus.hits, bus.mismatches} !== {1'b1, 3'd4, 8'd0}) begin
            errors++; $display("FAIL clamp_pass: pass=%b hits=%0d mism=%0d expected 1 4 0", bus.pass, bus.hits, bus.mismatches);
        end
    endtask

    task automatic test_we_during_run();
        load_entry(2'd0, 32'h14, 32'd21);
        do_start(3'd1, 1'b1);
        load_entry(2'd0, 32'h20, 32'd99);
        store(32'h14, 32'd21);
        checks++;
        if ({bus.pass, bus.hits} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL we_run_first: pass=%b hits=%0d expected 1 1", bus.pass, bus.hits);
        end
        do_start(3'd1, 1'b1);
        store(32'h14, 32'd21);
        checks++;
        if ({bus.pass, bus.hits, bus.mismatches} !== {1'b1, 3'd1, 8'd0}) begin
            errors++; $display("FAIL we_run_rerun: pass=%b hits=%0d mism=%0d expected 1 1 0", bus.pass, bus.hits, bus.mismatches);
        end
    endtask

    task automatic test_restart();
        load_entry(2'd0, 32'h0, 32'd4);
        load_entry(2'd1, 32'hc, 32'h0c);
        do_start(3'd2, 1'b1);
        store(32'h0, 32'd4);
        tick();
        do_start(3'd2, 1'b1);
        checks++;
        if ({bus.busy, bus.hits, bus.cycles} !== {1'b1, 3'd0, 32'd0}) begin
            errors++; $display("FAIL restart_clear: busy=%b hits=%0d cycles=%0d expected 1 0 0", bus.busy, bus.hits, bus.cycles);
        end
        store(32'h0, 32'd4);
        store(32'hc, 32'h0c);
        checks++;
        if ({bus.pass, bus.hits, bus.cycles} !== {1'b1, 3'd2, 32'd2}) begin
            errors++; $display("FAIL restart_pass: pass=%b hits=%0d cycles=%0d expected 1 2 2", bus.pass, bus.hits, bus.cycles);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(3'd2, 1'b0);
        store(32'h0, 32'd4);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout, bus.hits, bus.mismatches, bus.cycles} !== '0) begin
            errors++; $display("FAIL midrun_reset: busy=%b done=%b hits=%0d mism=%0d cycles=%0d expected all 0",
                               bus.busy, bus.done, bus.hits, bus.mismatches, bus.cycles);
        end
        #1 reset = 1'b1;
        tick();
        do_start(3'd2, 1'b0);
        store(32'h0, 32'd4);
        store(32'hc, 32'h0c);
        checks++;
        if ({bus.busy, bus.hits, bus.mismatches, bus.bad_addr, bus.bad_data} !== {1'b1, 3'd0, 8'd2, 32'h0, 32'd4}) begin
            errors++; $display("FAIL midrun_empty_table: busy=%b hits=%0d mism=%0d addr=%0h data=%0h expected 1 0 2 0 4",
                               bus.busy, bus.hits, bus.mismatches, bus.bad_addr, bus.bad_data);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_ordered_single();
        test_ordered_reverse();
        test_unordered();
        test_duplicate();
        test_timeout();
        test_count_zero();
        test_count_clamp();
        test_we_during_run();
        test_restart();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
